// File: rtl/md_unit_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state encodings and
// operation select values.
package md_unit_iter_pkg;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdRun  = 2'd1,
    MdDone = 2'd2
  } mdState_e;

  localparam logic MdOpMul = 1'b0;
  localparam logic MdOpDiv = 1'b1;

endpackage

// File: rtl/md_unit_iter_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface md_unit_iter_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             op_div;
  logic             is_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op_div, is_signed, src_a, src_b, cancel,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op_div, is_signed, src_a, src_b, cancel,
    output busy, done, result_hi, result_lo, div_by_zero
  );

endinterface

// File: rtl/md_unit_iter_div_step.sv
// One combinational restoring-divide step: compare the shifted partial remainder against
// the divisor, subtract when it fits and emit the quotient bit.
module md_unit_iter_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH-1:0] diff;

  // Trial subtraction; when it fits the true difference is below the divisor, so the low
  // WIDTH bits of the subtraction are exact.
  always_comb begin
    qBit   = (remIn >= {1'b0, divisor});
    diff   = remIn[WIDTH-1:0] - divisor;
    remOut = qBit ? diff : remIn[WIDTH-1:0];
  end

endmodule

// File: rtl/md_unit_iter.sv
// Iterative radix-2 multiply/divide unit with start/busy/done handshake and flush cancel.
// hi = high product / remainder, lo = low product / quotient.
// Optional macro MD_FAST_MUL_EN: multiplies complete through a single registered
// WIDTH x WIDTH multiplier instead of the iterative engine.
module md_unit_iter
  import md_unit_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  md_unit_iter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mdState_e         state;
  logic [CNT_W-1:0] cnt;
  logic             opDivQ;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] operandQ;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic             busyQ;
  logic             doneQ;
  logic             dbzQ;

  logic             inSignA;
  logic             inSignB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] divRem;
  logic             divQBit;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fixHi;
  logic [WIDTH-1:0] fixLo;

  md_unit_iter_div_step #(
    .WIDTH(WIDTH)
  ) u_divStep (
    .remIn  ({accHi, accLo[WIDTH-1]}),
    .divisor(operandQ),
    .remOut (divRem),
    .qBit   (divQBit)
  );

  // Operand magnitudes and signs for the incoming request.
  always_comb begin
    inSignA = bus.is_signed & bus.src_a[WIDTH-1];
    inSignB = bus.is_signed & bus.src_b[WIDTH-1];
    absA    = inSignA ? -bus.src_a : bus.src_a;
    absB    = inSignB ? -bus.src_b : bus.src_b;
  end

  // One engine step plus the sign fix-up applied to its result on the final iteration.
  always_comb begin
    mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operandQ} : '0);
    if (opDivQ) begin
      stepHi = divRem;
      stepLo = {accLo[WIDTH-2:0], divQBit};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
    prod = {stepHi, stepLo};
    if (opDivQ) begin
      fixLo = (signA ^ signB) ? -stepLo : stepLo;
      fixHi = signA ? -stepHi : stepHi;
    end else begin
      if (signA ^ signB) begin
        prod = -prod;
      end
      fixHi = prod[2*WIDTH-1:WIDTH];
      fixLo = prod[WIDTH-1:0];
    end
  end

`ifdef MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;

  // Single-cycle signed/unsigned product from the operand magnitudes.
  always_comb begin
    fastProd = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};
    if (inSignA ^ inSignB) begin
      fastProd = -fastProd;
    end
  end
`endif

  // FSM, iteration counter, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MdIdle;
      cnt      <= '0;
      opDivQ   <= MdOpMul;
      signA    <= 1'b0;
      signB    <= 1'b0;
      operandQ <= '0;
      accHi    <= '0;
      accLo    <= '0;
      resHi    <= '0;
      resLo    <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      dbzQ     <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        MdIdle: begin
          if (bus.start && !bus.cancel) begin
            opDivQ <= bus.op_div;
            signA  <= inSignA;
            signB  <= inSignB;
            busyQ  <= 1'b1;
            dbzQ   <= 1'b0;
            if (bus.op_div == MdOpDiv && bus.src_b == '0) begin
              resHi <= bus.src_a;
              resLo <= '1;
              dbzQ  <= 1'b1;
              doneQ <= 1'b1;
              state <= MdDone;
            end
`ifdef MD_FAST_MUL_EN
            else if (bus.op_div == MdOpMul) begin
              resHi <= fastProd[2*WIDTH-1:WIDTH];
              resLo <= fastProd[WIDTH-1:0];
              doneQ <= 1'b1;
              state <= MdDone;
            end
`endif
            else begin
              // Divide: accLo shifts the dividend out; multiply: accLo shifts the multiplier.
              operandQ <= bus.op_div ? absB : absA;
              accHi    <= '0;
              accLo    <= bus.op_div ? absA : absB;
              cnt      <= CNT_W'(WIDTH);
              state    <= MdRun;
            end
          end
        end
        MdRun: begin
          if (bus.cancel) begin
            busyQ <= 1'b0;
            state <= MdIdle;
          end else begin
            accHi <= stepHi;
            accLo <= stepLo;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              resHi <= fixHi;
              resLo <= fixLo;
              doneQ <= 1'b1;
              state <= MdDone;
            end
          end
        end
        MdDone: begin
          busyQ <= 1'b0;
          state <= MdIdle;
        end
        default: begin
          busyQ <= 1'b0;
          state <= MdIdle;
        end
      endcase
    end
  end

  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;
  assign bus.result_hi   = resHi;
  assign bus.result_lo   = resLo;
  assign bus.div_by_zero = dbzQ;

endmodule

// File: tb/tb_md_unit_iter.sv
// Self-checking bench for md_unit_iter: a directed vector table on a 32-bit instance plus
// hand-written cancel, held-start, sticky divide-by-zero and async-reset sequences, and
// an 8-bit instance for the narrow build. Honours MD_FAST_MUL_EN for multiply latency.
module tb_md_unit_iter;

`ifdef MD_FAST_MUL_EN
  localparam int MulLat  = 1;
  localparam int MulLat8 = 1;
`else
  localparam int MulLat  = 33;
  localparam int MulLat8 = 9;
`endif
  localparam int DivLat  = 33;

  typedef struct {
    logic        opDiv;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
    int          expLat;
  } vec_t;

  logic clk;
  logic rst;
  int   nCmp;
  int   nErr;

  md_unit_iter_if #(.WIDTH(32)) bus ();
  md_unit_iter_if #(.WIDTH(8))  bus8 ();

  md_unit_iter #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  md_unit_iter #(.WIDTH(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op on the 32-bit unit; returns in the first IDLE cycle after done.
  task automatic runOp(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz);
    @(negedge clk);
    bus.op_div    = d;
    bus.is_signed = s;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    hi  = 'x;
    lo  = 'x;
    dbz = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) begin
        lat = k;
        hi  = bus.result_hi;
        lo  = bus.result_lo;
        dbz = bus.div_by_zero;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runOp8(input logic d, input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [7:0] hi, output logic [7:0] lo);
    @(negedge clk);
    bus8.op_div    = d;
    bus8.is_signed = s;
    bus8.src_a     = a;
    bus8.src_b     = b;
    bus8.start     = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    lat = -1;
    hi  = 'x;
    lo  = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (bus8.done) begin
        lat = k;
        hi  = bus8.result_hi;
        lo  = bus8.result_lo;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[12];
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    int          nDone;
    int          firstAt;
    int          secondAt;
    logic        seenDone;

    nCmp = 0;
    nErr = 0;
    //           div   sgn   a             b             hi            lo        dbz  lat
    vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MulLat};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MulLat};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DivLat};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, DivLat};
    vecs[5]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DivLat};
    vecs[6]  = '{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, MulLat};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, MulLat};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DivLat};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, DivLat};
    vecs[10] = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, MulLat};
    vecs[11] = '{1'b1, 1'b0, 32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000, 1'b0, DivLat};

    bus.start  = 1'b0;  bus.op_div  = 1'b0;  bus.is_signed  = 1'b0;
    bus.src_a  = '0;    bus.src_b   = '0;    bus.cancel     = 1'b0;
    bus8.start = 1'b0;  bus8.op_div = 1'b0;  bus8.is_signed = 1'b0;
    bus8.src_a = '0;    bus8.src_b  = '0;    bus8.cancel    = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.result_hi), 64'd0);
    check("reset lo", 64'(bus.result_lo), 64'd0);
    check("reset dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i].opDiv, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, hi, lo, dbz);
      check($sformatf("vec%0d lat", i), 64'(lat), 64'(vecs[i].expLat));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].expHi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].expLo));
      check($sformatf("vec%0d dbz", i), 64'(dbz), 64'(vecs[i].expDbz));
    end

    // start together with cancel in IDLE is not accepted.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start+cancel busy", 64'(bus.busy), 64'd0);

    // Divide-by-zero flag stays set while idle and clears on the next accept.
    runOp(1'b1, 1'b1, 32'h00000005, 32'h00000000, lat, hi, lo, dbz);
    repeat (3) @(posedge clk);
    #1;
    check("dbz sticky", 64'(bus.div_by_zero), 64'd1);
    check("dbz hold hi", 64'(bus.result_hi), 64'h5);
    runOp(1'b0, 1'b0, 32'd3, 32'd4, lat, hi, lo, dbz);
    check("dbz cleared", 64'(dbz), 64'd0);
    check("mul 3*4 lo", 64'(lo), 64'd12);

    // Cancel during RUN: no done, busy drops, results keep 3*4.
    @(negedge clk);
    bus.op_div    = 1'b1;
    bus.is_signed = 1'b0;
    bus.src_a     = 32'd100;
    bus.src_b     = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seenDone  = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (bus.done) seenDone = 1'b1;
      @(posedge clk);
      #1;
    end
    check("cancel busy c10", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel busy c11", 64'(bus.busy), 64'd0);
    check("cancel done c11", 64'(bus.done | seenDone), 64'd0);
    check("cancel hold hi", 64'(bus.result_hi), 64'd0);
    check("cancel hold lo", 64'(bus.result_lo), 64'd12);
    runOp(1'b1, 1'b0, 32'd100, 32'd7, lat, hi, lo, dbz);
    check("post-cancel lat", 64'(lat), 64'(DivLat));
    check("post-cancel lo", 64'(lo), 64'd14);
    check("post-cancel hi", 64'(hi), 64'd2);

    // start held high through DONE: ignored there, re-accepted once back in IDLE.
    @(negedge clk);
    bus.op_div    = 1'b1;
    bus.is_signed = 1'b1;
    bus.src_a     = 32'h80000000;
    bus.src_b     = 32'hFFFFFFFF;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    nDone    = 0;
    firstAt  = -1;
    secondAt = -1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 35) bus.start = 1'b0;
      if (k == 34) check("held start idle c34", 64'(bus.busy), 64'd0);
      if (bus.done) begin
        nDone++;
        if (nDone == 1) firstAt = k;
        if (nDone == 2) secondAt = k;
      end
      @(posedge clk);
      #1;
    end
    check("held start pulses", 64'(nDone), 64'd2);
    check("held start first", 64'(firstAt), 64'd33);
    check("held start second", 64'(secondAt), 64'd67);
    check("held start lo", 64'(bus.result_lo), 64'h80000000);
    check("held start hi", 64'(bus.result_hi), 64'h0);

    // Async reset mid-divide clears outputs without a clock edge.
    runOp(1'b1, 1'b0, 32'd100, 32'd7, lat, hi, lo, dbz);
    @(negedge clk);
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst hi", 64'(bus.result_hi), 64'd0);
    check("async rst lo", 64'(bus.result_lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Narrow build.
    runOp8(1'b1, 1'b0, 8'hC8, 8'h07, lat, hi8, lo8);
    check("w8 div lat", 64'(lat), 64'd9);
    check("w8 div lo", 64'(lo8), 64'h1C);
    check("w8 div hi", 64'(hi8), 64'h04);
    runOp8(1'b0, 1'b1, 8'hF6, 8'h07, lat, hi8, lo8);
    check("w8 mul lat", 64'(lat), 64'(MulLat8));
    check("w8 mul hi", 64'(hi8), 64'hFF);
    check("w8 mul lo", 64'(lo8), 64'hBA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
